alu_execute: RTL
================

ALU_EXECUTE -- requirements
Module: alu_execute

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath width.
REQ-002 SHALL have parameter NB_ADDR, default 5, shift-amount width (log2 NB_DATA).
REQ-003 SHALL have parameter NB_ALU_OPCODE, default 4, ALU opcode width.
REQ-004 SHALL have ports, one per line:
 i_clock  in  1  single clock, rising edge.
 i_reset  in  1  synchronous, active-high reset.
 i_valid  in  1  upstream operation present.
 o_ready  out 1  block accepts operation this cycle.
 i_alu_opcode  in  NB_ALU_OPCODE  operation code.
 i_first_ope_rt  in  1  first operand is rt, not rs.
 i_second_ope_sa  in  1  second operand is zero-extended i_shamt.
 i_second_ope_rs  in  1  second operand is rs.
 i_rs  in  NB_DATA  register rs value.
 i_rt_imm  in  NB_DATA  rt value or extended immediate, muxed upstream.
 i_shamt  in  NB_ADDR  instruction sa field.
 o_result  out  NB_DATA  registered result.
 o_zero  out  1  o_result == 0.
 o_valid  out 1  o_result holds an unconsumed result.
 i_ready  in  1  downstream consumes result.

Function
REQ-005 SHALL accept an operation on a cycle with i_valid && o_ready; all operand/opcode inputs sampled only then.
REQ-006 SHALL form A = i_first_ope_rt ? i_rt_imm : i_rs; B = i_second_ope_sa ? {0,i_shamt} : i_second_ope_rs ? i_rs : i_rt_imm; sa wins if both select flags set.
REQ-007 SHALL decode: SLL 0000, SRAV 0001, SRL 0010, SRA 0011, SRLV 0110, NOR 0111, ADD 1000, SLT 1001, SLLV 1010, SUB 1011, AND 1100, OR 1101, XOR 1110, LUI 1111.
REQ-008 SHALL, for shifts, shift A by B[NB_ADDR-1:0]; SRA/SRAV replicate A MSB, SLL/SRL/SLLV/SRLV fill zero.
REQ-009 SHALL compute ADD=A+B, SUB=A-B modulo 2^NB_DATA, no overflow flag; SLT=1 if A<B signed else 0; LUI=B<<16; AND/OR/XOR/NOR bitwise.
REQ-010 SHALL produce 0 for undefined opcodes 0100, 0101.
REQ-011 SHALL run FSM IDLE/SHIFT/HOLD: IDLE->HOLD on accepted single-cycle op; IDLE->SHIFT on accepted shift with amount>0 (serial mode); SHIFT->HOLD when counter reaches 0; HOLD->IDLE when i_ready.
REQ-012 SHALL assert o_valid exactly in HOLD; o_result, o_zero stable while o_valid && !i_ready.
REQ-013 SHALL drive o_ready = (IDLE) || (HOLD && i_ready), allowing back-to-back issue; HOLD with same-cycle drain and accept transitions directly to HOLD or SHIFT.
REQ-014 SHALL give latency 1 cycle (accept edge to o_valid) for non-serial ops.

Reset
REQ-015 SHALL, on i_reset at a clock edge, enter IDLE, o_valid=0, o_result=0, o_zero=1, shift counter 0; any in-flight shift discarded.
REQ-016 SHALL give i_reset priority over accept and drain in the same cycle.

Configuration
REQ-017 SHALL, with ALU_SERIAL_SHIFT_EN defined, execute shifts 1 bit per cycle: amount n>0 gives o_valid n+1 cycles after accept; n=0 behaves as 1-cycle op.
REQ-018 SHALL, without ALU_SERIAL_SHIFT_EN, use a single-cycle barrel shifter; SHIFT state and counter absent; every op latency 1.

Structure
REQ-019 SHALL place ALU opcode localparams and NB_* defaults in shared package alu_pkg, also used by alu_control.
REQ-020 SHALL isolate shift logic in sub-module alu_shifter (serial or barrel per macro).

Verification
REQ-021 ADD 0x7FFFFFFF+0x00000001, i_ready=1 -> next cycle o_valid=1, o_result=0x80000000, o_zero=0.
REQ-022 SUB 5-5 via i_second_ope_rs, rs=rt=5 -> o_result=0, o_zero=1; SLT A=0xFFFFFFFF,B=1 -> 1.
REQ-023 SRA A=0x80000000, shamt=4, serial -> o_valid 5 cycles after accept, o_result=0xF8000000, o_ready=0 meanwhile.
REQ-024 LUI B=0x00001234, i_ready=0 for 3 cycles -> o_result=0x12340000 held, o_ready=0; drain cycle with new i_valid accepted back-to-back.
REQ-025 i_reset during SRLV amount 20 at cycle 6 -> o_valid=0, o_result=0, o_zero=1, o_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath defaults, opcode encodings, shift classes and FSM states.
// ALU_SERIAL_SHIFT_EN adds the SHIFT state used by the bit-serial shifter.
package alu_pkg;

  localparam int NB_DATA_DEF       = 32;
  localparam int NB_ADDR_DEF       = 5;
  localparam int NB_ALU_OPCODE_DEF = 4;

  typedef logic [NB_ALU_OPCODE_DEF-1:0] alu_op_t;

  localparam alu_op_t ALU_SLL  = 4'b0000;
  localparam alu_op_t ALU_SRAV = 4'b0001;
  localparam alu_op_t ALU_SRL  = 4'b0010;
  localparam alu_op_t ALU_SRA  = 4'b0011;
  localparam alu_op_t ALU_SRLV = 4'b0110;
  localparam alu_op_t ALU_NOR  = 4'b0111;
  localparam alu_op_t ALU_ADD  = 4'b1000;
  localparam alu_op_t ALU_SLT  = 4'b1001;
  localparam alu_op_t ALU_SLLV = 4'b1010;
  localparam alu_op_t ALU_SUB  = 4'b1011;
  localparam alu_op_t ALU_AND  = 4'b1100;
  localparam alu_op_t ALU_OR   = 4'b1101;
  localparam alu_op_t ALU_XOR  = 4'b1110;
  localparam alu_op_t ALU_LUI  = 4'b1111;

  typedef enum logic [1:0] {
    SHIFT_LEFT        = 2'd0,
    SHIFT_RIGHT_LOGIC = 2'd1,
    SHIFT_RIGHT_ARITH = 2'd2
  } shift_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1
`ifdef ALU_SERIAL_SHIFT_EN
    ,
    ST_SHIFT = 2'd2
`endif
  } state_e;

  function automatic logic is_shift_op(input alu_op_t op);
    case (op)
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic shift_dir_e shift_dir(input alu_op_t op);
    case (op)
      ALU_SRA, ALU_SRAV: return SHIFT_RIGHT_ARITH;
      ALU_SRL, ALU_SRLV: return SHIFT_RIGHT_LOGIC;
      default:           return SHIFT_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit: single-cycle barrel shifter by default, or a 1-bit-per-cycle
// serial shifter when ALU_SERIAL_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
`ifdef ALU_SERIAL_SHIFT_EN
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load,
  output logic               o_done,
`endif
  input  shift_dir_e         i_dir,
  input  logic [NB_DATA-1:0] i_data,
  input  logic [NB_ADDR-1:0] i_amount,
  output logic [NB_DATA-1:0] o_result
);

`ifdef ALU_SERIAL_SHIFT_EN

  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_ADDR-1:0] count_q, count_d;
  shift_dir_e         dir_q, dir_d;
  logic [NB_DATA-1:0] step_data;

  always_comb begin
    case (dir_q)
      SHIFT_RIGHT_LOGIC: step_data = {1'b0, data_q[NB_DATA-1:1]};
      SHIFT_RIGHT_ARITH: step_data = {data_q[NB_DATA-1], data_q[NB_DATA-1:1]};
      default:           step_data = {data_q[NB_DATA-2:0], 1'b0};
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    data_d  = data_q;
    count_d = count_q;
    dir_d   = dir_q;
    if (i_load) begin
      data_d  = i_data;
      count_d = i_amount;
      dir_d   = i_dir;
    end else if (count_q != '0) begin
      data_d  = step_data;
      count_d = count_q - NB_ADDR'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (i_reset) begin
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= SHIFT_LEFT;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // While idle the unit passes its operand through, which is a shift by zero.
  assign o_result = (count_q != '0) ? step_data : i_data;
  assign o_done   = (count_q == NB_ADDR'(1));

`else

  always_comb begin
    case (i_dir)
      SHIFT_RIGHT_LOGIC: o_result = i_data >> i_amount;
      SHIFT_RIGHT_ARITH: o_result = $signed(i_data) >>> i_amount;
      default:           o_result = i_data << i_amount;
    endcase
  end

`endif

endmodule

// File: rtl/alu_execute.sv
// ALU execute stage with valid/ready handshake and a registered result.
// Define ALU_SERIAL_SHIFT_EN to execute shifts serially (1 bit per cycle).
module alu_execute
  import alu_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_ADDR       = NB_ADDR_DEF,
  parameter int NB_ALU_OPCODE = NB_ALU_OPCODE_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [NB_ALU_OPCODE-1:0] i_alu_opcode,
  input  logic                     i_first_ope_rt,
  input  logic                     i_second_ope_sa,
  input  logic                     i_second_ope_rs,
  input  logic [NB_DATA-1:0]       i_rs,
  input  logic [NB_DATA-1:0]       i_rt_imm,
  input  logic [NB_ADDR-1:0]       i_shamt,
  output logic [NB_DATA-1:0]       o_result,
  output logic                     o_zero,
  output logic                     o_valid,
  input  logic                     i_ready
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic [NB_DATA-1:0] opnd_a, opnd_b;
  logic [NB_DATA-1:0] alu_result;
  logic [NB_DATA-1:0] shift_result;
  logic [NB_ADDR-1:0] shift_amount;
  logic               accept;

  always_comb begin
    opnd_a = i_first_ope_rt ? i_rt_imm : i_rs;
    if (i_second_ope_sa) begin
      opnd_b = {{(NB_DATA-NB_ADDR){1'b0}}, i_shamt};
    end else if (i_second_ope_rs) begin
      opnd_b = i_rs;
    end else begin
      opnd_b = i_rt_imm;
    end
  end

  assign shift_amount = opnd_b[NB_ADDR-1:0];
  assign o_ready      = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && i_ready);
  assign accept       = i_valid && o_ready;

`ifdef ALU_SERIAL_SHIFT_EN
  logic shift_done;
  logic start_serial;

  assign start_serial = accept && is_shift_op(i_alu_opcode) && (shift_amount != '0);

  alu_shifter #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_shifter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (start_serial),
    .o_done   (shift_done),
    .i_dir    (shift_dir(i_alu_opcode)),
    .i_data   (opnd_a),
    .i_amount (shift_amount),
    .o_result (shift_result)
  );
`else
  alu_shifter #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_shifter (
    .i_dir    (shift_dir(i_alu_opcode)),
    .i_data   (opnd_a),
    .i_amount (shift_amount),
    .o_result (shift_result)
  );
`endif

  always_comb begin
    case (i_alu_opcode)
      ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLLV, ALU_SRLV, ALU_SRAV: alu_result = shift_result;
      ALU_ADD: alu_result = opnd_a + opnd_b;
      ALU_SUB: alu_result = opnd_a - opnd_b;
      ALU_SLT: alu_result = {{(NB_DATA-1){1'b0}}, ($signed(opnd_a) < $signed(opnd_b))};
      ALU_AND: alu_result = opnd_a & opnd_b;
      ALU_OR:  alu_result = opnd_a | opnd_b;
      ALU_XOR: alu_result = opnd_a ^ opnd_b;
      ALU_NOR: alu_result = ~(opnd_a | opnd_b);
      ALU_LUI: alu_result = opnd_b << 16;
      default: alu_result = '0;
    endcase
  end

  // A draining HOLD may accept in the same cycle, so accept overrides the return to IDLE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if ((state_q == ST_HOLD) && i_ready) begin
          state_d = ST_IDLE;
        end
        if (accept) begin
          state_d  = ST_HOLD;
          result_d = alu_result;
`ifdef ALU_SERIAL_SHIFT_EN
          if (start_serial) begin
            state_d = ST_SHIFT;
          end
`endif
        end
      end
`ifdef ALU_SERIAL_SHIFT_EN
      ST_SHIFT: begin
        if (shift_done) begin
          state_d  = ST_HOLD;
          result_d = shift_result;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;
  assign o_zero   = (result_q == '0);
  assign o_valid  = (state_q == ST_HOLD);

endmodule
